engine_read_write_sequencer: RTL and testbench
==============================================

# engine_read_write_sequencer

Sequencer and flow controller for the read/write engine datapath kernel.
- Latches a ReadWriteConfigurationParameters set and accepts packets over a valid/ready handshake.
- Drives each accepted packet into the kernel with the configuration held stable, and tracks the kernel's fixed pipeline latency with a valid shift register.
- Buffers each kernel {address, result} pair as a memory request in a credit-guarded FIFO.
- Sits between the engine's input packet stream and the memory request arbiter.

## Interface
Parameters:
- FIFO_DEPTH, 16: request FIFO entries; power of two, ≥ PIPE_LATENCY+2.
- PIPE_LATENCY, 2: cycles from kernel data valid to kernel result registered.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  reset; synchronous, active-high.
- clear_in  in  1  synchronous flush to IDLE.
- config_valid_in  in  1  configuration strobe.
- config_in  in  ReadWriteConfigurationParameters  configuration set.
- write_mode_in  in  1  1 = write requests, 0 = read; latched with config.
- stop_in  in  1  end-of-stream pulse.
- data_valid_in / data_ready_out  in / out  1  input handshake.
- data_in  in  EnginePacketData  input packet.
- kernel_clear_out, kernel_config_valid_out, kernel_data_valid_out  out  1 each  kernel controls.
- kernel_config_out  out  ReadWriteConfigurationParameters  latched configuration.
- kernel_data_out  out  EnginePacketData  registered packet to kernel.
- kernel_address_in  in  PacketDataAddress  kernel address result.
- kernel_result_in  in  EnginePacketData  kernel data result.
- req_valid_out / req_ready_in  out / in  1  request handshake.
- req_out  out  ReadWriteRequestPacket  request: {cmd, address, data}.
- busy_out, done_out  out  1 each  status.
- req_count_out  out  32  requests retired since config.

## Operation
- States:
  - IDLE → CONFIG when config_valid_in. In the same cycle, latch config_in and write_mode_in and zero req_count_out.
  - CONFIG → RUN after 1 cycle. This lets the kernel see stable config.
  - RUN → DRAIN on stop_in.
  - DRAIN → DONE when pipe valids == 0, FIFO empty and no input handshake in flight.
  - DONE → CONFIG on config_valid_in.
  - DONE → IDLE on clear_in.
- kernel_config_valid_out = 1 in CONFIG, RUN and DRAIN.
- Credits:
  - outstanding = (pipe valid count) + (FIFO occupancy).
  - data_ready_out = (state == RUN) && (outstanding < FIFO_DEPTH − 1).
  - The FIFO therefore never overflows, and no push is ever dropped.
- Pipeline:
  - On an input handshake, register data_in into kernel_data_out and pulse kernel_data_valid_out for 1 cycle.
  - Shift the valid into a PIPE_LATENCY-deep shift register.
  - When the tail bit is 1, push {write_mode, kernel_address_in, kernel_result_in} into the FIFO.
- Request output:
  - FIFO head drives req_out; req_valid_out = !empty.
  - Pop on req_valid_out && req_ready_in; req_count_out increments on each pop (wraps at 2^32).
  - req_out is held stable while req_valid_out && !req_ready_in.
- Simultaneous events:
  - A push and a pop in the same cycle leave occupancy unchanged; this is legal even when the FIFO is full.
  - stop_in in the same cycle as a handshake: the packet is accepted, then the state moves to DRAIN.
  - config_valid_in outside IDLE/DONE is ignored.
- clear_in (any state) or areset:
  - Flush the FIFO and pipe valids; state → IDLE.
  - kernel_clear_out = 1 for that cycle.
  - Accepted in-flight packets are discarded.
- Outputs:
  - busy_out = state ∉ {IDLE, DONE}.
  - done_out = 1 while in DONE.
- Reset values: every output 0; config registers 0.

## Timing
- Handshake accepted at edge t:
  - kernel_data_valid_out high in cycle t+1.
  - FIFO push at edge t+1+PIPE_LATENCY.
  - req_valid_out high from t+2+PIPE_LATENCY (t+4 at default) if the FIFO was empty.
- Sustained throughput is 1 request/cycle when req_ready_in is held 1.
- data_ready_out deasserts the cycle after outstanding reaches FIFO_DEPTH−1.
- After DRAIN empties, done_out rises 1 cycle later.

## Configuration
- ENGINE_READ_WRITE_SEQUENCER_PERF_EN:
  - Defined: add out port stall_count_out[31:0]. It counts cycles with req_valid_out && !req_ready_in, is zeroed on config latch, clear_in and areset, and saturates at 0xFFFF_FFFF.
  - Undefined: the port and the counter are absent.

## Structure
- Shared package gets:
  - ReadWriteRequestPacket typedef (cmd 1b, PacketDataAddress, EnginePacketData).
  - ReadWriteSequencerState enum {IDLE, CONFIG, RUN, DRAIN, DONE}.
  - Default FIFO_DEPTH constant.
- One sub-module: engine_read_write_request_fifo.
  - Synchronous show-ahead FIFO of ReadWriteRequestPacket.
  - Ports: push, pop, full, empty, occupancy, and flush tied to clear_in.

## Test plan
- Config with index_start=0x100, granularity=2, write_mode=1; send 1 packet with field[1]=4 → single req with cmd=1, address offset 0x410, at t+4; req_count_out=1.
- Stream 32 back-to-back packets, req_ready_in=1 → 32 requests on consecutive cycles, in order; data_ready_out never drops.
- Hold req_ready_in=0 → data_ready_out drops after 15 outstanding (FIFO_DEPTH=16); no loss; release gives 15 in-order requests.
- stop_in with 3 packets in flight → DRAIN; done_out rises 1 cycle after the 3rd pop.
- clear_in mid-RUN with 5 outstanding → next cycle IDLE, req_valid_out=0, kernel_clear_out pulse, req_count_out=0.
- Perf build, req_ready_in=0 for 7 cycles with req_valid_out high → stall_count_out=7.

Source files
------------

// File: rtl/engine_read_write_sequencer_pkg.sv
// Shared types and defaults for the read/write engine sequencer and its request FIFO.
package engine_read_write_sequencer_pkg;

  localparam int DEFAULT_FIFO_DEPTH   = 16;
  localparam int DEFAULT_PIPE_LATENCY = 2;

  typedef logic [31:0] PacketDataAddress;

  typedef struct packed {
    logic [3:0][31:0] field;
  } EnginePacketData;

  typedef struct packed {
    PacketDataAddress index_start;
    PacketDataAddress index_end;
    PacketDataAddress array_pointer;
    logic [7:0]       granularity;
  } ReadWriteConfigurationParameters;

  typedef struct packed {
    logic             cmd;
    PacketDataAddress address;
    EnginePacketData  data;
  } ReadWriteRequestPacket;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ReadWriteSequencerState;

endpackage

// File: rtl/engine_read_write_request_fifo.sv
// Show-ahead request FIFO: the head entry is visible on pop_data whenever empty is low.
module engine_read_write_request_fifo
  import engine_read_write_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic                       flush,
  input  logic                       push,
  input  ReadWriteRequestPacket      push_data,
  input  logic                       pop,
  output ReadWriteRequestPacket      pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);

  ReadWriteRequestPacket mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge ap_clk) begin
    if (areset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left unreset; the pointers and count alone decide what is valid.
  always_ff @(posedge ap_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data  = mem[rd_ptr];
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign occupancy = count;

endmodule

// File: rtl/engine_read_write_sequencer.sv
// Sequencer/flow controller feeding the read/write kernel and buffering its memory requests.
// Optional ENGINE_READ_WRITE_SEQUENCER_PERF_EN adds stall_count_out (request back-pressure cycles).
module engine_read_write_sequencer
  import engine_read_write_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int PIPE_LATENCY = DEFAULT_PIPE_LATENCY
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            clear_in,
  input  logic                            config_valid_in,
  input  ReadWriteConfigurationParameters config_in,
  input  logic                            write_mode_in,
  input  logic                            stop_in,
  input  logic                            data_valid_in,
  output logic                            data_ready_out,
  input  EnginePacketData                 data_in,
  output logic                            kernel_clear_out,
  output logic                            kernel_config_valid_out,
  output logic                            kernel_data_valid_out,
  output ReadWriteConfigurationParameters kernel_config_out,
  output EnginePacketData                 kernel_data_out,
  input  PacketDataAddress                kernel_address_in,
  input  EnginePacketData                 kernel_result_in,
  output logic                            req_valid_out,
  input  logic                            req_ready_in,
  output ReadWriteRequestPacket           req_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [31:0]                     req_count_out
`ifdef ENGINE_READ_WRITE_SEQUENCER_PERF_EN
  ,
  output logic [31:0]                     stall_count_out
`endif
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_CONFIG = CONFIG;
  localparam logic [2:0] ST_RUN    = RUN;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam int OW = $clog2(FIFO_DEPTH) + 2;

  logic [2:0]                      state;
  ReadWriteConfigurationParameters cfg_q;
  logic                            write_mode_q;
  logic                            dv_q;
  logic [PIPE_LATENCY-1:0]         pipe_q;
  logic [31:0]                     req_count_q;

  logic                            fifo_push;
  logic                            fifo_pop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]     fifo_occupancy;
  ReadWriteRequestPacket           fifo_push_data;

  logic [OW-1:0]                   outstanding;
  logic                            handshake;
  logic                            cfg_latch;

  // Every packet past the handshake holds a credit until its request leaves the FIFO.
  assign outstanding    = OW'(dv_q) + OW'($countones(pipe_q)) + OW'(fifo_occupancy);
  assign data_ready_out = (state == ST_RUN) && (outstanding < OW'(FIFO_DEPTH - 1)) && !fifo_full;
  assign handshake      = data_valid_in && data_ready_out;
  assign cfg_latch      = config_valid_in && ((state == ST_IDLE) || (state == ST_DONE));

  assign fifo_push      = pipe_q[PIPE_LATENCY-1];
  assign fifo_push_data = '{cmd: write_mode_q, address: kernel_address_in, data: kernel_result_in};
  assign fifo_pop       = req_valid_out && req_ready_in;

  engine_read_write_request_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_request_fifo (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .flush     (clear_in),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (req_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occupancy)
  );

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state            <= ST_IDLE;
      cfg_q            <= '0;
      write_mode_q     <= 1'b0;
      dv_q             <= 1'b0;
      pipe_q           <= '0;
      kernel_data_out  <= '0;
      kernel_clear_out <= 1'b0;
      req_count_q      <= '0;
    end else if (clear_in) begin
      // The configuration survives a flush; only in-flight work is dropped.
      state            <= ST_IDLE;
      dv_q             <= 1'b0;
      pipe_q           <= '0;
      kernel_clear_out <= 1'b1;
      req_count_q      <= '0;
    end else begin
      kernel_clear_out <= 1'b0;
      dv_q             <= handshake;
      pipe_q           <= PIPE_LATENCY'({pipe_q, dv_q});
      if (handshake) kernel_data_out <= data_in;

      if (cfg_latch) begin
        cfg_q        <= config_in;
        write_mode_q <= write_mode_in;
        req_count_q  <= '0;
      end else if (fifo_pop) begin
        req_count_q  <= req_count_q + 32'd1;
      end

      case (state)
        ST_IDLE:   if (cfg_latch) state <= ST_CONFIG;
        ST_CONFIG: state <= ST_RUN;
        ST_RUN:    if (stop_in) state <= ST_DRAIN;
        ST_DRAIN:  if (!dv_q && (pipe_q == '0) && fifo_empty) state <= ST_DONE;
        ST_DONE:   if (cfg_latch) state <= ST_CONFIG;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign kernel_config_out       = cfg_q;
  assign kernel_data_valid_out   = dv_q;
  assign kernel_config_valid_out = (state == ST_CONFIG) || (state == ST_RUN) || (state == ST_DRAIN);
  assign req_valid_out           = !fifo_empty;
  assign busy_out                = (state != ST_IDLE) && (state != ST_DONE);
  assign done_out                = (state == ST_DONE);
  assign req_count_out           = req_count_q;

`ifdef ENGINE_READ_WRITE_SEQUENCER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge ap_clk) begin
    if (areset || clear_in || cfg_latch) begin
      stall_q <= '0;
    end else if (req_valid_out && !req_ready_in && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count_out = stall_q;
`endif

endmodule

// File: tb/tb_engine_read_write_sequencer.sv
// Directed bench for engine_read_write_sequencer with a behavioural two-stage kernel model.
module tb_engine_read_write_sequencer;
  import engine_read_write_sequencer_pkg::*;

  logic                            ap_clk = 1'b0;
  logic                            areset;
  logic                            clear_in;
  logic                            config_valid_in;
  ReadWriteConfigurationParameters config_in;
  logic                            write_mode_in;
  logic                            stop_in;
  logic                            data_valid_in;
  logic                            data_ready_out;
  EnginePacketData                 data_in;
  logic                            kernel_clear_out;
  logic                            kernel_config_valid_out;
  logic                            kernel_data_valid_out;
  ReadWriteConfigurationParameters kernel_config_out;
  EnginePacketData                 kernel_data_out;
  PacketDataAddress                kernel_address_in;
  EnginePacketData                 kernel_result_in;
  logic                            req_valid_out;
  logic                            req_ready_in;
  ReadWriteRequestPacket           req_out;
  logic                            busy_out;
  logic                            done_out;
  logic [31:0]                     req_count_out;
`ifdef ENGINE_READ_WRITE_SEQUENCER_PERF_EN
  logic [31:0]                     stall_count_out;
`endif

  int tests = 0;
  int fails = 0;

  ReadWriteRequestPacket exp_q[$];

  always #5 ap_clk = ~ap_clk;

  engine_read_write_sequencer dut (
    .ap_clk                  (ap_clk),
    .areset                  (areset),
    .clear_in                (clear_in),
    .config_valid_in         (config_valid_in),
    .config_in               (config_in),
    .write_mode_in           (write_mode_in),
    .stop_in                 (stop_in),
    .data_valid_in           (data_valid_in),
    .data_ready_out          (data_ready_out),
    .data_in                 (data_in),
    .kernel_clear_out        (kernel_clear_out),
    .kernel_config_valid_out (kernel_config_valid_out),
    .kernel_data_valid_out   (kernel_data_valid_out),
    .kernel_config_out       (kernel_config_out),
    .kernel_data_out         (kernel_data_out),
    .kernel_address_in       (kernel_address_in),
    .kernel_result_in        (kernel_result_in),
    .req_valid_out           (req_valid_out),
    .req_ready_in            (req_ready_in),
    .req_out                 (req_out),
    .busy_out                (busy_out),
    .done_out                (done_out),
    .req_count_out           (req_count_out)
`ifdef ENGINE_READ_WRITE_SEQUENCER_PERF_EN
    ,
    .stall_count_out         (stall_count_out)
`endif
  );

  // Kernel stand-in: address = (index_start + field[1]) << granularity, result = packet with field[0]+1,
  // registered twice so the result lines up with a 2-cycle pipeline latency.
  PacketDataAddress k1_addr, k2_addr;
  EnginePacketData  k1_res, k2_res;

  always @(posedge ap_clk) begin
    k1_addr <= (kernel_config_out.index_start + kernel_data_out.field[1]) << kernel_config_out.granularity;
    k1_res  <= kernel_data_out;
    k1_res.field[0] <= kernel_data_out.field[0] + 32'd1;
    k2_addr <= k1_addr;
    k2_res  <= k1_res;
  end

  assign kernel_address_in = k2_addr;
  assign kernel_result_in  = k2_res;

  function automatic EnginePacketData mk_pkt(int i);
    EnginePacketData p;
    p.field[0] = 32'h1000 + 32'(i);
    p.field[1] = 32'(i);
    p.field[2] = 32'hDEAD_0000 | 32'(i);
    p.field[3] = ~32'(i);
    return p;
  endfunction

  function automatic ReadWriteRequestPacket exp_req(EnginePacketData d, logic wm,
                                                    logic [31:0] idx, logic [7:0] gran);
    ReadWriteRequestPacket r;
    r.cmd           = wm;
    r.address       = (idx + d.field[1]) << gran;
    r.data          = d;
    r.data.field[0] = d.field[0] + 32'd1;
    return r;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic configure(logic [31:0] idx, logic [7:0] gran, logic wm);
    config_in       = '{index_start: idx, index_end: idx + 32'h100,
                        array_pointer: 32'h8000_0000, granularity: gran};
    write_mode_in   = wm;
    config_valid_in = 1'b1;
    tick();
    config_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    clear_in = 0; config_valid_in = 0; config_in = '0; write_mode_in = 0; stop_in = 0;
    data_valid_in = 0; data_in = '0; req_ready_in = 0;
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0;
    tick();
    tests++;
    if ({data_ready_out, kernel_clear_out, kernel_config_valid_out, kernel_data_valid_out,
         req_valid_out, busy_out, done_out} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000", {data_ready_out, kernel_clear_out,
               kernel_config_valid_out, kernel_data_valid_out, req_valid_out, busy_out, done_out});
    end
    tests++;
    if (req_count_out !== 32'd0) begin
      fails++; $display("FAIL reset_req_count: got %h expected 0", req_count_out);
    end
    tests++;
    if (kernel_config_out !== '0) begin
      fails++; $display("FAIL reset_config: got %h expected 0", kernel_config_out);
    end
    tests++;
    if (kernel_data_out !== '0) begin
      fails++; $display("FAIL reset_kernel_data: got %h expected 0", kernel_data_out);
    end
  endtask

  task automatic test_single_request();
    EnginePacketData p, ep;
    configure(32'h100, 8'd2, 1'b1);
    tests++;
    if ({busy_out, kernel_config_valid_out, data_ready_out, done_out} !== 4'b1100) begin
      fails++; $display("FAIL config_state: got %b expected 1100",
                        {busy_out, kernel_config_valid_out, data_ready_out, done_out});
    end
    tests++;
    if (kernel_config_out.index_start !== 32'h100 || kernel_config_out.granularity !== 8'd2) begin
      fails++; $display("FAIL config_latch: got %h/%h expected 100/02",
                        kernel_config_out.index_start, kernel_config_out.granularity);
    end
    tick();
    tests++;
    if (data_ready_out !== 1'b1) begin
      fails++; $display("FAIL run_ready: got %b expected 1", data_ready_out);
    end
    p.field[0] = 32'h55; p.field[1] = 32'h4; p.field[2] = 32'hAA; p.field[3] = 32'hCAFE;
    ep = p; ep.field[0] = 32'h56;
    data_in = p; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    tests++;
    if (kernel_data_valid_out !== 1'b1 || kernel_data_out !== p) begin
      fails++; $display("FAIL kernel_drive: got %b/%h expected 1/%h", kernel_data_valid_out, kernel_data_out, p);
    end
    tick();
    tests++;
    if (kernel_data_valid_out !== 1'b0) begin
      fails++; $display("FAIL kernel_valid_pulse: got %b expected 0", kernel_data_valid_out);
    end
    tick();
    tests++;
    if (req_valid_out !== 1'b0) begin
      fails++; $display("FAIL req_not_early: got %b expected 0", req_valid_out);
    end
    tick();
    tests++;
    if (req_valid_out !== 1'b1) begin
      fails++; $display("FAIL req_latency: got %b expected 1", req_valid_out);
    end
    tests++;
    if (req_out.cmd !== 1'b1 || req_out.address !== 32'h410 || req_out.data !== ep) begin
      fails++; $display("FAIL single_req: got %h expected %h", req_out, {1'b1, 32'h410, ep});
    end
    req_ready_in = 1'b1;
    tick();
    req_ready_in = 1'b0;
    tests++;
    if (req_valid_out !== 1'b0 || req_count_out !== 32'd1) begin
      fails++; $display("FAIL single_pop: got %b/%0d expected 0/1", req_valid_out, req_count_out);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1, drops = 0;
    exp_q.delete();
    req_ready_in = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (req_valid_out) begin
        tests++;
        if (exp_q.size() == 0 || req_out !== exp_q[0]) begin
          fails++; $display("FAIL b2b_req[%0d]: got %h", got, req_out);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (sent < 32) begin
        data_valid_in = 1'b1;
        data_in       = mk_pkt(sent);
        if (!data_ready_out) drops++;
        else begin
          exp_q.push_back(exp_req(data_in, 1'b1, 32'h100, 8'd2));
          sent++;
        end
      end else begin
        data_valid_in = 1'b0;
      end
      tick();
    end
    data_valid_in = 1'b0;
    req_ready_in  = 1'b0;
    tests++;
    if (drops !== 0) begin
      fails++; $display("FAIL b2b_ready_drop: got %0d drops expected 0", drops);
    end
    tests++;
    if (got !== 32) begin
      fails++; $display("FAIL b2b_count: got %0d expected 32", got);
    end
    tests++;
    if (last - first !== 31) begin
      fails++; $display("FAIL b2b_consecutive: got span %0d expected 31", last - first);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, first_low = -1, got = 0, first = -1, last = -1;
    exp_q.delete();
    req_ready_in = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      data_valid_in = 1'b1;
      data_in       = mk_pkt(100 + sent);
      if (data_ready_out) begin
        exp_q.push_back(exp_req(data_in, 1'b1, 32'h100, 8'd2));
        sent++;
      end else if (first_low < 0) begin
        first_low = cyc;
      end
      tick();
    end
    data_valid_in = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (sent !== 15) begin
      fails++; $display("FAIL bp_accepted: got %0d expected 15", sent);
    end
    tests++;
    if (first_low !== 15) begin
      fails++; $display("FAIL bp_ready_drop_cycle: got %0d expected 15", first_low);
    end
    tests++;
    if (data_ready_out !== 1'b0 || req_valid_out !== 1'b1) begin
      fails++; $display("FAIL bp_held: got ready=%b valid=%b expected 0/1", data_ready_out, req_valid_out);
    end
    req_ready_in = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (req_valid_out) begin
        tests++;
        if (exp_q.size() == 0 || req_out !== exp_q[0]) begin
          fails++; $display("FAIL bp_req[%0d]: got %h", got, req_out);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      tick();
    end
    req_ready_in = 1'b0;
    tests++;
    if (got !== 15 || last - first !== 14) begin
      fails++; $display("FAIL bp_release: got %0d reqs span %0d expected 15/14", got, last - first);
    end
    tests++;
    if (data_ready_out !== 1'b1 || req_count_out !== 32'd48) begin
      fails++; $display("FAIL bp_after: got ready=%b count=%0d expected 1/48", data_ready_out, req_count_out);
    end
  endtask

  task automatic test_drain_done();
    exp_q.delete();
    req_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_valid_in = 1'b1;
      data_in       = mk_pkt(200 + i);
      stop_in       = (i == 2);
      tests++;
      if (data_ready_out !== 1'b1) begin
        fails++; $display("FAIL drain_accept[%0d]: got %b expected 1", i, data_ready_out);
      end
      exp_q.push_back(exp_req(data_in, 1'b1, 32'h100, 8'd2));
      tick();
    end
    data_valid_in = 1'b0;
    stop_in       = 1'b0;
    tests++;
    if ({busy_out, data_ready_out, done_out} !== 3'b100) begin
      fails++; $display("FAIL drain_state: got %b expected 100", {busy_out, data_ready_out, done_out});
    end
    tick(); tick(); tick(); tick();
    tests++;
    if (done_out !== 1'b0 || req_valid_out !== 1'b1) begin
      fails++; $display("FAIL drain_pending: got done=%b valid=%b expected 0/1", done_out, req_valid_out);
    end
    req_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (req_valid_out !== 1'b1 || exp_q.size() == 0 || req_out !== exp_q[0]) begin
        fails++; $display("FAIL drain_req[%0d]: got %b/%h", k, req_valid_out, req_out);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
    end
    req_ready_in = 1'b0;
    tests++;
    if (done_out !== 1'b0 || req_valid_out !== 1'b0) begin
      fails++; $display("FAIL drain_last_pop: got done=%b valid=%b expected 0/0", done_out, req_valid_out);
    end
    tick();
    tests++;
    if (done_out !== 1'b1 || busy_out !== 1'b0 || req_count_out !== 32'd51) begin
      fails++; $display("FAIL done_rise: got done=%b busy=%b count=%0d expected 1/0/51",
                        done_out, busy_out, req_count_out);
    end
  endtask

  task automatic test_read_mode();
    int w = 0;
    configure(32'h20, 8'd1, 1'b0);
    tests++;
    if (req_count_out !== 32'd0 || done_out !== 1'b0 || busy_out !== 1'b1) begin
      fails++; $display("FAIL reconfig: got count=%0d done=%b busy=%b expected 0/0/1",
                        req_count_out, done_out, busy_out);
    end
    tick();
    data_in = mk_pkt(7); data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    while (!req_valid_out && w < 10) begin tick(); w++; end
    tests++;
    if (req_valid_out !== 1'b1 || req_out.cmd !== 1'b0 || req_out.address !== 32'h4E) begin
      fails++; $display("FAIL read_req: got valid=%b cmd=%b addr=%h expected 1/0/0000004e",
                        req_valid_out, req_out.cmd, req_out.address);
    end
    req_ready_in = 1'b1;
    tick();
    req_ready_in = 1'b0;
    tests++;
    if (req_count_out !== 32'd1) begin
      fails++; $display("FAIL read_count: got %0d expected 1", req_count_out);
    end
  endtask

  task automatic test_clear();
    int leaks = 0;
    req_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_valid_in = 1'b1; data_in = mk_pkt(300 + i);
      tick();
    end
    data_valid_in = 1'b0;
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    tests++;
    if ({busy_out, req_valid_out, kernel_clear_out, data_ready_out, kernel_data_valid_out} !== 5'b00100) begin
      fails++; $display("FAIL clear_state: got %b expected 00100",
                        {busy_out, req_valid_out, kernel_clear_out, data_ready_out, kernel_data_valid_out});
    end
    tests++;
    if (req_count_out !== 32'd0) begin
      fails++; $display("FAIL clear_count: got %0d expected 0", req_count_out);
    end
    tick();
    tests++;
    if (kernel_clear_out !== 1'b0) begin
      fails++; $display("FAIL clear_pulse: got %b expected 0", kernel_clear_out);
    end
    for (int i = 0; i < 6; i++) begin
      if (req_valid_out !== 1'b0) leaks++;
      tick();
    end
    tests++;
    if (leaks !== 0) begin
      fails++; $display("FAIL clear_discard: got %0d valid cycles expected 0", leaks);
    end
  endtask

  task automatic test_config_ignored();
    configure(32'h300, 8'd3, 1'b1);
    tick();
    config_in       = '{index_start: 32'h999, index_end: 32'h0, array_pointer: 32'h0, granularity: 8'd7};
    write_mode_in   = 1'b0;
    config_valid_in = 1'b1;
    tick();
    config_valid_in = 1'b0;
    tests++;
    if (kernel_config_out.index_start !== 32'h300 || kernel_config_out.granularity !== 8'd3) begin
      fails++; $display("FAIL cfg_ignored: got %h/%h expected 300/03",
                        kernel_config_out.index_start, kernel_config_out.granularity);
    end
    tests++;
    if ({busy_out, data_ready_out, done_out} !== 3'b110) begin
      fails++; $display("FAIL cfg_ignored_state: got %b expected 110", {busy_out, data_ready_out, done_out});
    end
  endtask

`ifdef ENGINE_READ_WRITE_SEQUENCER_PERF_EN
  task automatic test_perf();
    int w = 0;
    req_ready_in = 1'b0;
    data_in = mk_pkt(9); data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    while (!req_valid_out && w < 10) begin tick(); w++; end
    tests++;
    if (req_valid_out !== 1'b1 || stall_count_out !== 32'd0) begin
      fails++; $display("FAIL perf_start: got valid=%b stall=%0d expected 1/0", req_valid_out, stall_count_out);
    end
    for (int i = 0; i < 7; i++) tick();
    tests++;
    if (stall_count_out !== 32'd7) begin
      fails++; $display("FAIL perf_stall: got %0d expected 7", stall_count_out);
    end
    req_ready_in = 1'b1;
    tick();
    req_ready_in = 1'b0;
    tests++;
    if (stall_count_out !== 32'd7) begin
      fails++; $display("FAIL perf_hold: got %0d expected 7", stall_count_out);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_request();
    test_back_to_back();
    test_backpressure();
    test_drain_done();
    test_read_mode();
    test_clear();
    test_config_ignored();
`ifdef ENGINE_READ_WRITE_SEQUENCER_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
